rs_age_issue: RTL

RS_AGE_ISSUE -- requirements
Module: rs_age_issue

---
 rtl/rs_age_issue_pkg.sv | 14 +
 rtl/rs_oldest_sel.sv | 42 ++++
 rtl/rs_age_issue.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rs_age_issue_pkg.sv
// Dispatch constants shared by the reservation-station files. The DP_NUM_WIDTH
// and DP_NUM macros come from constants.vh when present; otherwise they fall back here.
`ifndef DP_NUM_WIDTH
`define DP_NUM_WIDTH 2
`endif
`ifndef DP_NUM
`define DP_NUM 2
`endif

package rs_age_issue_pkg;
  localparam int DP_NUM   = `DP_NUM;
  localparam int DP_NUM_W = `DP_NUM_WIDTH;
  localparam int SRC_NUM  = 2;
endpackage

// File: rtl/rs_oldest_sel.sv
// Issue picker: oldest eligible entry from the age matrix when RS_AGE_ORDER_EN is
// defined, otherwise (and as a fallback) the lowest-index eligible entry.
module rs_oldest_sel
  import rs_age_issue_pkg::*;
#(
  parameter int ENT_NUM = 8,
  parameter int ENT_SEL = 3
) (
  input  logic [ENT_NUM-1:0]         i_elig,
`ifdef RS_AGE_ORDER_EN
  input  logic [ENT_NUM*ENT_NUM-1:0] i_age,
`endif
  output logic                       o_vld,
  output logic [ENT_SEL-1:0]         o_sel
);

  logic [ENT_NUM-1:0] w_cand;
  logic [ENT_NUM-1:0] w_pick;

`ifdef RS_AGE_ORDER_EN
  // Row i holds the entries older than i; a candidate has no older eligible peer.
  always_comb begin
    w_cand = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      w_cand[i] = i_elig[i] && !(|(i_age[i*ENT_NUM +: ENT_NUM] & i_elig));
    end
  end
`else
  assign w_cand = i_elig;
`endif

  assign w_pick = (|w_cand) ? w_cand : i_elig;

  always_comb begin
    o_vld = |i_elig;
    o_sel = '0;
    for (int i = ENT_NUM - 1; i >= 0; i--) begin
      if (w_pick[i]) o_sel = ENT_SEL'(i);
    end
  end

endmodule

// File: rtl/rs_age_issue.sv
// Reservation station: two-slot dispatch, tag wakeup with same-cycle bypass and a
// stall-stable issue port. RS_AGE_ORDER_EN selects oldest-first issue via an age matrix.
module rs_age_issue
  import rs_age_issue_pkg::*;
#(
  parameter int ENT_NUM = 8,
  parameter int ENT_SEL = 3,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter int WB_NUM  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_dp_vld,
  input  logic [`DP_NUM_WIDTH-1:0]        i_req_num,
  input  logic [DP_NUM*DATA_W-1:0]        i_dp_data,
  input  logic [DP_NUM*SRC_NUM*TAG_W-1:0] i_dp_tag,
  input  logic [DP_NUM*SRC_NUM-1:0]       i_dp_rdy,
  output logic                            o_allocable,
  input  logic [WB_NUM-1:0]               i_wb_vld,
  input  logic [WB_NUM*TAG_W-1:0]         i_wb_tag,
  output logic                            o_issue_vld,
  input  logic                            i_issue_rdy,
  output logic [ENT_SEL-1:0]              o_issue_sel,
  output logic [DATA_W-1:0]               o_issue_data,
  input  logic                            i_flush,
  output logic [ENT_SEL:0]                o_busy_cnt
);

  logic [ENT_NUM-1:0] r_busy, r_rdy1, r_rdy2;
  logic [TAG_W-1:0]   r_tag1 [ENT_NUM];
  logic [TAG_W-1:0]   r_tag2 [ENT_NUM];
  logic [DATA_W-1:0]  r_data [ENT_NUM];
  logic [ENT_SEL:0]   r_busy_cnt;
  logic               r_hold;
  logic [ENT_SEL-1:0] r_hold_sel;

  logic [ENT_NUM-1:0] w_busy_nxt, w_rdy1_nxt, w_rdy2_nxt, w_elig;
  logic [ENT_SEL:0]   w_free_cnt, w_cnt_nxt, w_req_ext;
  logic               w_slot1_ok, w_slot2_ok;
  logic [ENT_SEL-1:0] w_slot1_idx, w_slot2_idx;
  logic               w_dp_go, w_dp_two, w_issue_fire, w_pick_vld;
  logic [ENT_SEL-1:0] w_pick_sel, w_sel;
  logic [TAG_W-1:0]   w_s1t1, w_s1t2, w_s2t1, w_s2t2;

  function automatic logic f_wb_hit(input logic [TAG_W-1:0] tag,
                                    input logic [WB_NUM-1:0] vld,
                                    input logic [WB_NUM*TAG_W-1:0] tags);
    f_wb_hit = 1'b0;
    for (int k = 0; k < WB_NUM; k++) begin
      if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) f_wb_hit = 1'b1;
    end
  endfunction

  assign w_s1t1 = i_dp_tag[0*TAG_W +: TAG_W];
  assign w_s1t2 = i_dp_tag[1*TAG_W +: TAG_W];
  assign w_s2t1 = i_dp_tag[2*TAG_W +: TAG_W];
  assign w_s2t2 = i_dp_tag[3*TAG_W +: TAG_W];

  // Free-slot search sees only the registered busy vector, so same-cycle issue never frees a slot.
  always_comb begin
    w_free_cnt  = '0;
    w_slot1_ok  = 1'b0;
    w_slot2_ok  = 1'b0;
    w_slot1_idx = '0;
    w_slot2_idx = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      w_free_cnt = w_free_cnt + {{ENT_SEL{1'b0}}, ~r_busy[i]};
      if (!r_busy[i]) begin
        if (!w_slot1_ok) begin
          w_slot1_ok  = 1'b1;
          w_slot1_idx = ENT_SEL'(i);
        end else if (!w_slot2_ok) begin
          w_slot2_ok  = 1'b1;
          w_slot2_idx = ENT_SEL'(i);
        end
      end
    end
  end

  assign w_req_ext   = (ENT_SEL+1)'(i_req_num);
  assign o_allocable = (w_free_cnt >= w_req_ext);
  assign w_dp_go     = i_dp_vld && o_allocable && (i_req_num != '0) && !i_flush;
  assign w_dp_two    = w_dp_go && (i_req_num >= DP_NUM_W'(DP_NUM));

  assign w_elig = r_busy & r_rdy1 & r_rdy2;

  always_comb begin
    w_busy_nxt = r_busy;
    w_rdy1_nxt = r_rdy1;
    w_rdy2_nxt = r_rdy2;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (r_busy[i] && f_wb_hit(r_tag1[i], i_wb_vld, i_wb_tag)) w_rdy1_nxt[i] = 1'b1;
      if (r_busy[i] && f_wb_hit(r_tag2[i], i_wb_vld, i_wb_tag)) w_rdy2_nxt[i] = 1'b1;
    end
    if (w_issue_fire) w_busy_nxt[w_sel] = 1'b0;
    if (w_dp_go) begin
      w_busy_nxt[w_slot1_idx] = 1'b1;
      w_rdy1_nxt[w_slot1_idx] = i_dp_rdy[0] | f_wb_hit(w_s1t1, i_wb_vld, i_wb_tag);
      w_rdy2_nxt[w_slot1_idx] = i_dp_rdy[1] | f_wb_hit(w_s1t2, i_wb_vld, i_wb_tag);
    end
    if (w_dp_two && w_slot2_ok) begin
      w_busy_nxt[w_slot2_idx] = 1'b1;
      w_rdy1_nxt[w_slot2_idx] = i_dp_rdy[2] | f_wb_hit(w_s2t1, i_wb_vld, i_wb_tag);
      w_rdy2_nxt[w_slot2_idx] = i_dp_rdy[3] | f_wb_hit(w_s2t2, i_wb_vld, i_wb_tag);
    end
    if (i_flush) w_busy_nxt = '0;
    w_cnt_nxt = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{ENT_SEL{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_rdy1     <= '0;
      r_rdy2     <= '0;
      r_busy_cnt <= '0;
      r_hold     <= 1'b0;
      r_hold_sel <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_rdy1     <= w_rdy1_nxt;
      r_rdy2     <= w_rdy2_nxt;
      r_busy_cnt <= w_cnt_nxt;
      r_hold     <= o_issue_vld && !i_issue_rdy;
      r_hold_sel <= w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (w_dp_go) begin
      r_tag1[w_slot1_idx] <= w_s1t1;
      r_tag2[w_slot1_idx] <= w_s1t2;
      r_data[w_slot1_idx] <= i_dp_data[0 +: DATA_W];
    end
    if (w_dp_two && w_slot2_ok) begin
      r_tag1[w_slot2_idx] <= w_s2t1;
      r_tag2[w_slot2_idx] <= w_s2t2;
      r_data[w_slot2_idx] <= i_dp_data[DATA_W +: DATA_W];
    end
  end

`ifdef RS_AGE_ORDER_EN
  logic [ENT_NUM-1:0]         r_age     [ENT_NUM];
  logic [ENT_NUM-1:0]         w_age_nxt [ENT_NUM];
  logic [ENT_NUM*ENT_NUM-1:0] w_age_flat;

  // A newly written entry is younger than everything: clear its column, load its row.
  always_comb begin
    w_age_flat = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      w_age_nxt[i] = r_age[i];
      if (w_dp_go) w_age_nxt[i][w_slot1_idx] = 1'b0;
      if (w_dp_two && w_slot2_ok) w_age_nxt[i][w_slot2_idx] = 1'b0;
      w_age_flat[i*ENT_NUM +: ENT_NUM] = r_age[i];
    end
    if (w_dp_go) w_age_nxt[w_slot1_idx] = r_busy;
    if (w_dp_two && w_slot2_ok) w_age_nxt[w_slot2_idx] = r_busy | (ENT_NUM'(1) << w_slot1_idx);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENT_NUM; i++) begin
      if (rst) r_age[i] <= '0;
      else     r_age[i] <= w_age_nxt[i];
    end
  end
`endif

  rs_oldest_sel #(
    .ENT_NUM (ENT_NUM),
    .ENT_SEL (ENT_SEL)
  ) u_oldest_sel (
    .i_elig (w_elig),
`ifdef RS_AGE_ORDER_EN
    .i_age  (w_age_flat),
`endif
    .o_vld  (w_pick_vld),
    .o_sel  (w_pick_sel)
  );

  // A stalled grant is pinned; the pinned entry stays eligible until it issues or is flushed.
  assign w_sel        = r_hold ? r_hold_sel : w_pick_sel;
  assign o_issue_vld  = w_pick_vld && !i_flush;
  assign o_issue_sel  = o_issue_vld ? w_sel : '0;
  assign o_issue_data = o_issue_vld ? r_data[w_sel] : '0;
  assign w_issue_fire = o_issue_vld && i_issue_rdy;
  assign o_busy_cnt   = r_busy_cnt;

endmodule
